// File: rtl/cnn_layer_accel_result_packer_if.sv
// cnn_layer_accel_result_packer_if
// Bundles the job-config, result-stream and packed-output handshakes of the
// result packer, plus its busy/done status.
//   master : the surrounding system (drives cfg, results, out_ready)
//   slave  : the packer itself
// Signals:
//   cfg_valid/cfg_accept/cfg_num_results : per-job result count
//   result_valid/result_accept/result_data : 16-bit quad result stream
//   out_valid/out_ready/out_data/out_keep/out_last : packed 128-bit words
//   busy/done : job status
interface cnn_layer_accel_result_packer_if #(
  parameter int unsigned C_RESULT_WIDTH = 16,
  parameter int unsigned C_LANES        = 8
);
  logic                              cfg_valid;
  logic                              cfg_accept;
  logic [31:0]                       cfg_num_results;
  logic                              result_valid;
  logic                              result_accept;
  logic [C_RESULT_WIDTH-1:0]         result_data;
  logic                              out_valid;
  logic                              out_ready;
  logic [C_RESULT_WIDTH*C_LANES-1:0] out_data;
  logic [C_LANES-1:0]                out_keep;
  logic                              out_last;
  logic                              busy;
  logic                              done;

  modport master (
    output cfg_valid, cfg_num_results, result_valid, result_data, out_ready,
    input  cfg_accept, result_accept, out_valid, out_data, out_keep, out_last, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_num_results, result_valid, result_data, out_ready,
    output cfg_accept, result_accept, out_valid, out_data, out_keep, out_last, busy, done
  );
endinterface

// File: rtl/cnn_layer_accel_result_packer.sv
// cnn_layer_accel_result_packer
// Packs C_LANES results of C_RESULT_WIDTH bits into one output word and queues
// words in a C_FIFO_DEPTH-entry FIFO. The final word of a job carries out_last
// and a lane mask; done pulses once that word has left the FIFO.
// Ports:
//   clk_if : clock (rising edge)
//   rst    : synchronous active-high reset
//   bus    : slave side of cnn_layer_accel_result_packer_if
module cnn_layer_accel_result_packer #(
  parameter int unsigned C_RESULT_WIDTH = 16,
  parameter int unsigned C_LANES        = 8,
  parameter int unsigned C_FIFO_DEPTH   = 4
) (
  input logic                            clk_if,
  input logic                            rst,
  cnn_layer_accel_result_packer_if.slave bus
);
  localparam int unsigned WordW = C_RESULT_WIDTH * C_LANES;
  localparam int unsigned LaneW = (C_LANES > 1) ? $clog2(C_LANES) : 1;
  localparam int unsigned PtrW  = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StCollect, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [31:0]        remaining_q, remaining_d;
  logic [LaneW-1:0]   lane_q, lane_d;
  logic [WordW-1:0]   pack_q, pack_d, pack_word;
  logic [C_LANES-1:0] keep_q, keep_d, keep_word;

  logic [WordW-1:0]        fifo_data_q [C_FIFO_DEPTH];
  logic [C_LANES-1:0]      fifo_keep_q [C_FIFO_DEPTH];
  logic [C_FIFO_DEPTH-1:0] fifo_last_q;
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]         count_q;

  logic fifo_full, fifo_empty;
  logic cfg_acc, res_acc;
  logic push, push_last, pop;

  // Full/empty come from the registered count only, so a same-cycle pop never
  // reopens result_accept until the following cycle.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(C_FIFO_DEPTH));
  assign pop        = !fifo_empty && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    lane_d      = lane_q;
    pack_d      = pack_q;
    keep_d      = keep_q;
    cfg_acc     = 1'b0;
    res_acc     = 1'b0;
    push        = 1'b0;
    push_last   = 1'b0;
    // Pack register with the incoming result merged in; this is what a push stores.
    pack_word   = pack_q;
    keep_word   = keep_q;
    pack_word[lane_q*C_RESULT_WIDTH +: C_RESULT_WIDTH] = bus.result_data;
    keep_word[lane_q] = 1'b1;

    unique case (state_q)
      StIdle: begin
        cfg_acc = 1'b1;
        if (bus.cfg_valid) begin
          remaining_d = bus.cfg_num_results;
          lane_d      = '0;
          pack_d      = '0;
          keep_d      = '0;
          state_d     = (bus.cfg_num_results == 32'd0) ? StDone : StCollect;
        end
      end
      StCollect: begin
        res_acc = !fifo_full && (remaining_q != 32'd0);
        if (bus.result_valid && res_acc) begin
          remaining_d = remaining_q - 32'd1;
          if (lane_q == LaneW'(C_LANES - 1) || remaining_q == 32'd1) begin
            push      = 1'b1;
            push_last = (remaining_q == 32'd1);
            pack_d    = '0;
            keep_d    = '0;
            lane_d    = '0;
            if (push_last) state_d = StDrain;
          end else begin
            pack_d = pack_word;
            keep_d = keep_word;
            lane_d = lane_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (fifo_empty) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_if) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      lane_q      <= '0;
      pack_q      <= '0;
      keep_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      lane_q      <= lane_d;
      pack_q      <= pack_d;
      keep_q      <= keep_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_if) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= pack_word;
      fifo_keep_q[wr_ptr_q] <= keep_word;
      fifo_last_q[wr_ptr_q] <= push_last;
    end
  end

  assign bus.cfg_accept    = cfg_acc;
  assign bus.result_accept = res_acc;
  assign bus.out_valid     = !fifo_empty;
  assign bus.out_data      = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
  assign bus.out_keep      = fifo_empty ? '0 : fifo_keep_q[rd_ptr_q];
  assign bus.out_last      = !fifo_empty && fifo_last_q[rd_ptr_q];
  assign bus.busy          = (state_q != StIdle);
  assign bus.done          = (state_q == StDone);
endmodule

// File: tb/tb_cnn_layer_accel_result_packer.sv
module tb_cnn_layer_accel_result_packer;
  localparam int W = 16;
  localparam int L = 8;
  localparam int D = 4;

  logic clk_if = 1'b0;
  logic rst    = 1'b1;
  always #5 clk_if = ~clk_if;

  cnn_layer_accel_result_packer_if #(.C_RESULT_WIDTH(W), .C_LANES(L)) bus ();

  cnn_layer_accel_result_packer #(
    .C_RESULT_WIDTH(W),
    .C_LANES       (L),
    .C_FIFO_DEPTH  (D)
  ) dut (
    .clk_if(clk_if),
    .rst   (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W*L-1:0] data;
    logic [L-1:0]   keep;
    logic           last;
  } word_t;

  typedef struct {
    int          n;
    int          exp_words;
    logic [L-1:0] last_keep;
  } vec_t;

  word_t        exp_q[$];
  int           errors = 0;
  int           checks = 0;
  int           words_seen = 0;
  int           done_seen = 0;
  int           acc_count = 0;
  logic [L-1:0] last_keep_seen = '0;

  task automatic check(input string name, input logic [W*L-1:0] act, input logic [W*L-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer plus hold-stability check during output stalls.
  task automatic monitor();
    word_t          w;
    bit             stall_prev = 1'b0;
    logic [W*L-1:0] held_data = '0;
    logic [L-1:0]   held_keep = '0;
    logic           held_last = 1'b0;
    forever begin
      @(negedge clk_if);
      if (bus.done) done_seen++;
      if (!rst) begin
        if (stall_prev && bus.out_valid) begin
          check("stall hold data", bus.out_data, held_data);
          check("stall hold keep", bus.out_keep, held_keep);
          check("stall hold last", bus.out_last, held_last);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected word", 1, 0);
          end else begin
            w = exp_q.pop_front();
            check("word data", bus.out_data, w.data);
            check("word keep", bus.out_keep, w.keep);
            check("word last", bus.out_last, w.last);
          end
          words_seen++;
          if (bus.out_last) last_keep_seen = bus.out_keep;
        end
      end
      stall_prev = !rst && bus.out_valid && !bus.out_ready;
      held_data  = bus.out_data;
      held_keep  = bus.out_keep;
      held_last  = bus.out_last;
    end
  endtask

  task automatic cfg_handshake(input int n);
    bit ok = 1'b0;
    int guard = 0;
    bus.cfg_valid       = 1'b1;
    bus.cfg_num_results = n;
    while (!ok && guard < 200) begin
      @(negedge clk_if);
      ok = bus.cfg_accept;
      @(posedge clk_if);
      #1;
      guard++;
    end
    bus.cfg_valid = 1'b0;
    check("cfg handshake", ok, 1);
  endtask

  // Offers results until max_acc are taken; builds expected words as they complete.
  task automatic drive_results(input int n, input int max_acc);
    logic [W*L-1:0] pk = '0;
    logic [L-1:0]   kp = '0;
    logic [W-1:0]   d;
    word_t          w;
    int lane = 0;
    int rem = n;
    int taken = 0;
    int guard = 0;
    bit ok;
    while (taken < max_acc && guard < n * 4 + 400) begin
      d = W'($urandom);
      bus.result_valid = 1'b1;
      bus.result_data  = d;
      @(negedge clk_if);
      ok = bus.result_accept;
      @(posedge clk_if);
      #1;
      guard++;
      if (ok) begin
        pk[lane*W +: W] = d;
        kp[lane] = 1'b1;
        lane++;
        rem--;
        taken++;
        acc_count++;
        if (lane == L || rem == 0) begin
          w.data = pk;
          w.keep = kp;
          w.last = (rem == 0);
          exp_q.push_back(w);
          pk   = '0;
          kp   = '0;
          lane = 0;
        end
      end
    end
    bus.result_valid = 1'b0;
    check("results taken", taken, max_acc);
  endtask

  // Returns at the falling edge where done is observed high.
  task automatic wait_done();
    int guard = 0;
    bit seen = 1'b0;
    while (!seen && guard < 2000) begin
      @(negedge clk_if);
      seen = bus.done;
      guard++;
    end
    check("done pulse", seen, 1);
  endtask

  vec_t tbl[5];
  int   w0;
  int   d0;

  initial begin
    bus.cfg_valid       = 1'b0;
    bus.cfg_num_results = '0;
    bus.result_valid    = 1'b0;
    bus.result_data     = '0;
    bus.out_ready       = 1'b1;

    tbl[0] = '{n: 2645, exp_words: 331, last_keep: 8'h1F};
    tbl[1] = '{n: 8,    exp_words: 1,   last_keep: 8'hFF};
    tbl[2] = '{n: 1,    exp_words: 1,   last_keep: 8'h01};
    tbl[3] = '{n: 16,   exp_words: 2,   last_keep: 8'hFF};
    tbl[4] = '{n: 13,   exp_words: 2,   last_keep: 8'h1F};

    fork
      monitor();
    join_none

    repeat (2) @(posedge clk_if);
    #1;
    rst = 1'b0;
    @(negedge clk_if);
    check("reset cfg_accept", bus.cfg_accept, 1);
    check("reset result_accept", bus.result_accept, 0);
    check("reset out_valid", bus.out_valid, 0);
    check("reset out_data", bus.out_data, 0);
    check("reset out_keep", bus.out_keep, 0);
    check("reset out_last", bus.out_last, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    @(posedge clk_if);
    #1;

    // Table-driven jobs with free-flowing output.
    for (int i = 0; i < 5; i++) begin
      w0 = words_seen;
      d0 = done_seen;
      cfg_handshake(tbl[i].n);
      drive_results(tbl[i].n, tbl[i].n);
      wait_done();
      @(posedge clk_if);
      #1;
      @(negedge clk_if);
      check("job word count", words_seen - w0, tbl[i].exp_words);
      check("job last keep", last_keep_seen, tbl[i].last_keep);
      check("job done count", done_seen - d0, 1);
      check("job queue empty", exp_q.size(), 0);
      @(posedge clk_if);
      #1;
    end

    // Backpressure: output stalled for 40 cycles.
    w0 = words_seen;
    acc_count = 0;
    bus.out_ready = 1'b0;
    fork
      begin
        cfg_handshake(64);
        drive_results(64, 64);
      end
      begin
        repeat (40) @(posedge clk_if);
        @(negedge clk_if);
        check("stall accepted count", acc_count, 32);
        check("stall result_accept", bus.result_accept, 0);
        @(posedge clk_if);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_done();
    @(posedge clk_if);
    #1;
    @(negedge clk_if);
    check("stall word count", words_seen - w0, 8);
    check("stall queue empty", exp_q.size(), 0);
    @(posedge clk_if);
    #1;

    // Second config offered while busy.
    w0 = words_seen;
    fork
      begin
        cfg_handshake(20);
        drive_results(20, 20);
      end
      begin
        repeat (5) @(posedge clk_if);
        #1;
        bus.cfg_valid       = 1'b1;
        bus.cfg_num_results = 12;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk_if);
          check("cfg held off while busy", bus.cfg_accept, 0);
        end
      end
    join
    wait_done();
    @(posedge clk_if);
    #1;
    @(negedge clk_if);
    check("cfg accept after done", bus.cfg_accept, 1);
    @(posedge clk_if);
    #1;
    bus.cfg_valid = 1'b0;
    drive_results(12, 12);
    wait_done();
    @(posedge clk_if);
    #1;
    @(negedge clk_if);
    check("busy-cfg word count", words_seen - w0, 5);
    check("busy-cfg last keep", last_keep_seen, 8'h0F);
    @(posedge clk_if);
    #1;

    // Zero-count job.
    w0 = words_seen;
    cfg_handshake(0);
    @(negedge clk_if);
    check("zero job done", bus.done, 1);
    check("zero job busy in done", bus.busy, 1);
    check("zero job out_valid", bus.out_valid, 0);
    @(posedge clk_if);
    #1;
    @(negedge clk_if);
    check("zero job done cleared", bus.done, 0);
    check("zero job busy cleared", bus.busy, 0);
    check("zero job cfg_accept", bus.cfg_accept, 1);
    check("zero job words", words_seen - w0, 0);
    @(posedge clk_if);
    #1;

    // Reset in the middle of a 100-result job.
    cfg_handshake(100);
    drive_results(100, 20);
    rst = 1'b1;
    @(posedge clk_if);
    #1;
    rst = 1'b0;
    exp_q.delete();
    d0 = done_seen;
    @(negedge clk_if);
    check("post-reset out_valid", bus.out_valid, 0);
    check("post-reset cfg_accept", bus.cfg_accept, 1);
    check("post-reset done", bus.done, 0);
    check("post-reset busy", bus.busy, 0);
    @(posedge clk_if);
    #1;
    w0 = words_seen;
    cfg_handshake(16);
    drive_results(16, 16);
    wait_done();
    @(posedge clk_if);
    #1;
    @(negedge clk_if);
    check("fresh job word count", words_seen - w0, 2);
    check("fresh job last keep", last_keep_seen, 8'hFF);
    check("fresh job single done", done_seen - d0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
